// File: rtl/spi_shift_engine.sv
// SPI shift engine: parallel load, serial shift in either bit order, with
// bit counting, a one-cycle completion pulse and abort. One block serves
// both the MOSI and MISO roles. sample_en and shift_en come from the SPI
// clock-edge generator.
module spi_shift_engine #(
  parameter int   DATA_LEN = 8,
  parameter logic IDLE_OUT = 1'b1,
  localparam int  CW       = $clog2(DATA_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                msb_first,
  input  logic                sample_en,
  input  logic                shift_en,
  input  logic                abort,
  input  logic                serial_in,
  output logic                serial_out,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic [CW-1:0]       bit_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state, state_n;
  logic [DATA_LEN-1:0] shreg, shifted;
  logic                mode;
  logic                sample_bit;
  logic                ins;
  logic                load, do_shift, do_abort, done;

  // The incoming bit bypasses the sample flop when sample and shift coincide.
  assign ins     = sample_en ? serial_in : sample_bit;
  assign shifted = mode ? {shreg[DATA_LEN-2:0], ins} : {ins, shreg[DATA_LEN-1:1]};

  assign tx_ready   = (state == IDLE);
  assign busy       = ~tx_ready;
  assign serial_out = (state == ACTIVE) ? (mode ? shreg[DATA_LEN-1] : shreg[0]) : IDLE_OUT;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and datapath strobes. Abort wins over shift and completion.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    do_shift = 1'b0;
    do_abort = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          load    = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          do_abort = 1'b1;
          state_n  = IDLE;
        end else if (shift_en) begin
          do_shift = 1'b1;
          if (bit_cnt == CW'(DATA_LEN - 1)) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, sample flop, counter and received-word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      mode       <= 1'b0;
      sample_bit <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      rx_valid <= done;
      if (load) begin
        shreg      <= tx_data;
        mode       <= msb_first;
        sample_bit <= 1'b0;
        bit_cnt    <= '0;
      end
      if (state == ACTIVE && !abort && sample_en) sample_bit <= serial_in;
      if (do_shift) begin
        shreg   <= shifted;
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (done)     rx_data <= shifted;
      if (do_abort) bit_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed scenarios plus random
// words checked against a bit-order model of the serial stream.
module tb_spi_shift_engine;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  tx_data;
  logic          tx_valid, tx_ready, msb_first, sample_en, shift_en, abort;
  logic          serial_in, serial_out, rx_valid, busy;
  logic [N-1:0]  rx_data;
  logic [CW-1:0] bit_cnt;
  logic          loop, ext_in;
  int            pass_cnt = 0;
  int            total    = 0;

  assign serial_in = loop ? serial_out : ext_in;

  spi_shift_engine #(.DATA_LEN(N), .IDLE_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .msb_first(msb_first), .sample_en(sample_en),
    .shift_en(shift_en), .abort(abort), .serial_in(serial_in),
    .serial_out(serial_out), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are observed 1 time unit after the edge.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [N-1:0] d, input logic m);
    tx_data = d; msb_first = m; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = N'($urandom); msb_first = 1'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b want 1", tx_ready); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (serial_out !== 1'b1) $display("FAIL rst_serial_out: got %b want 1", serial_out); else pass_cnt++;
    total++; if (rx_data !== '0) $display("FAIL rst_rx_data: got %h want 00", rx_data); else pass_cnt++;
    total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    total++; if (bit_cnt !== '0) $display("FAIL rst_bit_cnt: got %0d want 0", bit_cnt); else pass_cnt++;
  endtask

  // LSB-first loopback with separate sample then shift cycles.
  task automatic test_lsb_loopback(input logic [N-1:0] d);
    loop = 1'b1;
    load_word(d, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++; if (serial_out !== d[i]) $display("FAIL lsb_out[%0d]: got %b want %b", i, serial_out, d[i]); else pass_cnt++;
      sample_en = 1'b1; tick(); sample_en = 1'b0;
      shift_en  = 1'b1; tick(); shift_en  = 1'b0;
      if (i < N - 1) begin
        total++; if (bit_cnt !== CW'(i + 1)) $display("FAIL lsb_cnt[%0d]: got %0d want %0d", i, bit_cnt, i + 1); else pass_cnt++;
      end
    end
    total++; if (rx_valid !== 1'b1) $display("FAIL lsb_rx_valid: got %b want 1", rx_valid); else pass_cnt++;
    total++; if (rx_data !== d) $display("FAIL lsb_rx_data: got %h want %h", rx_data, d); else pass_cnt++;
    total++; if (bit_cnt !== CW'(N)) $display("FAIL lsb_done_cnt: got %0d want %0d", bit_cnt, N); else pass_cnt++;
    total++; if (tx_ready !== 1'b1) $display("FAIL lsb_done_ready: got %b want 1", tx_ready); else pass_cnt++;
    tick();
    total++; if (rx_valid !== 1'b0) $display("FAIL lsb_pulse_width: got %b want 0", rx_valid); else pass_cnt++;
  endtask

  // MSB-first transmit of 0x3C while receiving 0xC3, sample+shift every cycle.
  task automatic test_msb_ext;
    logic [N-1:0] d, r;
    d = 8'h3C; r = 8'hC3; loop = 1'b0;
    load_word(d, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++; if (serial_out !== d[N-1-i]) $display("FAIL msb_out[%0d]: got %b want %b", i, serial_out, d[N-1-i]); else pass_cnt++;
      ext_in = r[N-1-i]; sample_en = 1'b1; shift_en = 1'b1; tick();
    end
    sample_en = 1'b0; shift_en = 1'b0;
    total++; if (rx_valid !== 1'b1) $display("FAIL msb_rx_valid: got %b want 1", rx_valid); else pass_cnt++;
    total++; if (rx_data !== r) $display("FAIL msb_rx_data: got %h want %h", rx_data, r); else pass_cnt++;
    tick();
  endtask

  // 0x11 with an ignored mid-word load, then 0x22 loaded in the rx_valid cycle.
  task automatic test_back_to_back;
    logic [N-1:0] a, b;
    a = 8'h11; b = 8'h22; loop = 1'b1;
    load_word(a, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (i == 3) begin tx_valid = 1'b1; tx_data = 8'hEE; end
      sample_en = 1'b1; shift_en = 1'b1; tick();
      tx_valid = 1'b0;
      if (i == 3) begin
        total++; if (bit_cnt !== CW'(4)) $display("FAIL b2b_ignored_load_cnt: got %0d want 4", bit_cnt); else pass_cnt++;
      end
    end
    sample_en = 1'b0; shift_en = 1'b0;
    total++; if (rx_data !== a) $display("FAIL b2b_first_rx: got %h want %h", rx_data, a); else pass_cnt++;
    total++; if (rx_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", rx_valid); else pass_cnt++;
    load_word(b, 1'b1);
    total++; if (tx_ready !== 1'b0) $display("FAIL b2b_accept: got tx_ready=%b want 0", tx_ready); else pass_cnt++;
    total++; if (bit_cnt !== '0) $display("FAIL b2b_cnt0: got %0d want 0", bit_cnt); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      total++; if (serial_out !== b[N-1-i]) $display("FAIL b2b_out[%0d]: got %b want %b", i, serial_out, b[N-1-i]); else pass_cnt++;
      sample_en = 1'b1; shift_en = 1'b1; tick();
    end
    sample_en = 1'b0; shift_en = 1'b0;
    total++; if (rx_data !== b) $display("FAIL b2b_second_rx: got %h want %h", rx_data, b); else pass_cnt++;
    tick();
  endtask

  // Abort together with a shift after three bits.
  task automatic test_abort;
    logic [N-1:0] prev;
    prev = rx_data; loop = 1'b1;
    load_word(8'h96, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; shift_en = 1'b1; tick();
    end
    abort = 1'b1; tick();
    abort = 1'b0; sample_en = 1'b0; shift_en = 1'b0;
    total++; if (tx_ready !== 1'b1) $display("FAIL abort_idle: got tx_ready=%b want 1", tx_ready); else pass_cnt++;
    total++; if (bit_cnt !== '0) $display("FAIL abort_cnt: got %0d want 0", bit_cnt); else pass_cnt++;
    total++; if (serial_out !== 1'b1) $display("FAIL abort_out: got %b want 1", serial_out); else pass_cnt++;
    total++; if (rx_data !== prev) $display("FAIL abort_rx_data: got %h want %h", rx_data, prev); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_valid !== 1'b0) $display("FAIL abort_no_valid[%0d]: got %b want 0", i, rx_valid); else pass_cnt++;
      tick();
    end
  endtask

  // Reset after five shifts, then a clean 0x5A loopback.
  task automatic test_reset_mid;
    loop = 1'b1;
    load_word(8'h77, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1; shift_en = 1'b1; tick();
    end
    sample_en = 1'b0; shift_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_ready: got ready=%b busy=%b want 1/0", tx_ready, busy); else pass_cnt++;
    total++; if (bit_cnt !== '0) $display("FAIL rstmid_cnt: got %0d want 0", bit_cnt); else pass_cnt++;
    total++; if (rx_data !== '0 || rx_valid !== 1'b0) $display("FAIL rstmid_rx: got %h/%b want 00/0", rx_data, rx_valid); else pass_cnt++;
    total++; if (serial_out !== 1'b1) $display("FAIL rstmid_out: got %b want 1", serial_out); else pass_cnt++;
    test_lsb_loopback(8'h5A);
  endtask

  // Strobes in IDLE must not disturb anything.
  task automatic test_idle;
    logic [N-1:0]  d;
    logic [CW-1:0] c;
    d = rx_data; c = bit_cnt;
    for (int i = 0; i < 6; i++) begin
      sample_en = 1'($urandom); shift_en = 1'($urandom); abort = 1'($urandom); ext_in = 1'($urandom);
      loop = 1'b0; tick();
      total++; if (bit_cnt !== c || rx_data !== d || serial_out !== 1'b1 || tx_ready !== 1'b1)
        $display("FAIL idle[%0d]: got cnt=%0d rx=%h out=%b rdy=%b want %0d/%h/1/1", i, bit_cnt, rx_data, serial_out, tx_ready, c, d);
      else pass_cnt++;
    end
    sample_en = 1'b0; shift_en = 1'b0; abort = 1'b0;
  endtask

  // Random words, random order, random strobe patterns. The model maps the
  // k-th bit on the wire to word position N-1-k (MSB first) or k (LSB first).
  task automatic test_random;
    logic [N-1:0] d, exp_rx;
    logic         m, b;
    int           kind, pos;
    loop = 1'b0;
    for (int w = 0; w < 20; w++) begin
      d = N'($urandom); m = 1'($urandom); exp_rx = '0;
      load_word(d, m);
      for (int k = 0; k < N; k++) begin
        pos = m ? N - 1 - k : k;
        b = 1'($urandom); exp_rx[pos] = b;
        total++; if (bit_cnt !== CW'(k) || serial_out !== d[pos] || rx_valid !== 1'b0)
          $display("FAIL rnd_w%0d_b%0d: got cnt=%0d out=%b vld=%b want %0d/%b/0", w, k, bit_cnt, serial_out, rx_valid, k, d[pos]);
        else pass_cnt++;
        kind = $urandom_range(0, 2);
        if (kind == 1) begin
          ext_in = b; sample_en = 1'b1; tick(); sample_en = 1'b0;
          ext_in = ~b; shift_en = 1'b1; tick(); shift_en = 1'b0;
        end else begin
          if (kind == 2) begin ext_in = ~b; tick(); end
          ext_in = b; sample_en = 1'b1; shift_en = 1'b1; tick();
          sample_en = 1'b0; shift_en = 1'b0;
        end
      end
      total++; if (rx_valid !== 1'b1 || rx_data !== exp_rx || bit_cnt !== CW'(N))
        $display("FAIL rnd_w%0d_done: got vld=%b rx=%h cnt=%0d want 1/%h/%0d", w, rx_valid, rx_data, bit_cnt, exp_rx, N);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; msb_first = 1'b0;
    sample_en = 1'b0; shift_en = 1'b0; abort = 1'b0; loop = 1'b0; ext_in = 1'b0;
    test_reset();
    test_lsb_loopback(8'hA5);
    test_msb_ext();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised SPI shift engine: the next generation of the team's SPI parallel/serial shift register. It adds configurable word width, runtime MSB/LSB-first order, a valid/ready load handshake, an internal bit counter with a completion pulse, separate sample and shift strobes, and abort. It sits between the SPI master/slave clock-edge generator, which drives `sample_en` and `shift_en`, and the CPU-side data registers. The same block serves MOSI and MISO roles.

## Interface
Parameters:
- `DATA_LEN`, 8: word width in bits; must be ≥2.
- `IDLE_OUT`, 1'b1: level on `serial_out` while idle.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_data`  in  DATA_LEN  parallel word to transmit.
- `tx_valid`  in  1  load request.
- `tx_ready`  out  1  high when idle and able to accept a load.
- `msb_first`  in  1  bit order, latched at load: 1 = MSB first, 0 = LSB first.
- `sample_en`  in  1  capture `serial_in` into the sample bit.
- `shift_en`  in  1  shift one bit and advance the counter.
- `abort`  in  1  cancel the current word.
- `serial_in`  in  1  serial receive line.
- `serial_out`  out  1  serial transmit line.
- `rx_data`  out  DATA_LEN  last completely received word.
- `rx_valid`  out  1  one-cycle pulse when a word completes.
- `busy`  out  1  equals `~tx_ready`.
- `bit_cnt`  out  $clog2(DATA_LEN+1)  number of bits shifted in the current word.

## Operation
- Two states: IDLE and ACTIVE.
- IDLE:
  - `tx_ready`=1.
  - `sample_en`, `shift_en` and `abort` are ignored.
  - `serial_out`=`IDLE_OUT`.
- Load: `tx_valid && tx_ready` does all of the following on one edge:
  - shreg ← `tx_data`;
  - mode ← `msb_first`;
  - `bit_cnt` ← 0;
  - sample bit ← 0;
  - state → ACTIVE.
- ACTIVE, `serial_out`: shreg[DATA_LEN-1] if mode=1, else shreg[0]. It is combinational from shreg and mode.
- ACTIVE, `sample_en`: sample bit ← `serial_in`.
- ACTIVE, `shift_en`:
  - MSB mode: shreg ← {shreg[DATA_LEN-2:0], ins}.
  - LSB mode: shreg ← {ins, shreg[DATA_LEN-1:1]}.
  - In both modes, `bit_cnt` increments.
  - `ins` is the sample bit, except when `sample_en` is also high that cycle; then `ins` = `serial_in` (bypass), and the sample bit is also updated.
- Completion: `shift_en` with `bit_cnt`==DATA_LEN-1 does all of the following on the same edge:
  - `rx_data` ← the post-shift shreg value;
  - `rx_valid` ← 1;
  - `bit_cnt` ← DATA_LEN;
  - state → IDLE.
- `abort` in ACTIVE:
  - state → IDLE and `bit_cnt` ← 0.
  - `rx_data` is unchanged and no `rx_valid` pulse is issued.
  - `abort` takes priority over a simultaneous `shift_en`/completion.
- `tx_valid` while ACTIVE is ignored; nothing is queued.
- `bit_cnt` holds its value in IDLE until the next load (DATA_LEN after completion, 0 after abort or reset).

## Timing
- Reset values, applied on an edge with `rst`=1 and overriding everything else:
  - state IDLE, shreg 0, sample bit 0, mode 0;
  - `tx_ready`=1, `busy`=0;
  - `serial_out`=`IDLE_OUT`;
  - `rx_data`=0, `rx_valid`=0, `bit_cnt`=0.
- Reset mid-word discards the word with no `rx_valid`.
- Load latency: the first bit is on `serial_out` in the cycle after the load edge.
- `shift_en` is legal in that same cycle.
- `rx_valid` is high for exactly the one cycle following the completing edge. In that cycle `tx_ready`=1, so a new load in that cycle is accepted (back-to-back words).
- Minimum word time is DATA_LEN cycles (`shift_en` held high), plus one load cycle.
- `rx_data` is stable from the completion edge until the next completion or reset.
- No combinational path from any input to any output, except `serial_out` from internal state only.

## Test plan
- LSB loopback:
  - Stimulus: DATA_LEN=8, `serial_in`=`serial_out`, load 0xA5 with `msb_first`=0, then eight `sample_en`-then-`shift_en` pairs.
  - Required: `serial_out` sequence 1,0,1,0,0,1,0,1; `rx_data`=0xA5; `rx_valid` high for one cycle after the 8th shift; `bit_cnt`=8.
- MSB mode with external data:
  - Stimulus: load 0x3C with `msb_first`=1; drive `serial_in` with 0xC3 MSB-first, using simultaneous `sample_en`+`shift_en` every cycle.
  - Required: `serial_out` 0,0,1,1,1,1,0,0; `rx_data`=0xC3.
- Back-to-back and ignored load:
  - Stimulus: load 0x11, complete the word, then assert `tx_valid` with 0x22 in the `rx_valid` cycle; also assert `tx_valid` while ACTIVE.
  - Required: 0x22 is accepted with no idle gap, and the mid-word `tx_valid` is ignored.
- Abort:
  - Stimulus: after 3 shifts, assert `abort` together with `shift_en`.
  - Required: IDLE, `bit_cnt`=0, `serial_out`=1, `rx_valid` never asserts, `rx_data` keeps its previous value.
- Reset mid-word:
  - Stimulus: assert `rst` after 5 shifts.
  - Required: all outputs equal their reset values on the next edge; a subsequent 0x5A LSB loopback transfer completes correctly.
- Idle immunity:
  - Stimulus: toggle `shift_en`/`sample_en` in IDLE.
  - Required: `bit_cnt`, `rx_data` and `serial_out` are unchanged.
